riscv_base_muldiv: RTL

//  Multi-cycle RV32M/RV64M multiply/divide unit beside riscv_base_alu in EX stage.

---
 rtl/riscv_base_muldiv_pkg.sv | 34 +++
 rtl/riscv_base_div_iter.sv | 35 +++
 rtl/riscv_base_muldiv.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_base_muldiv_pkg.sv
// riscv_base_muldiv_pkg
//   Shared definitions for the RV32M/RV64M multiply/divide unit.
//   md_op_e : funct3 encodings of the M-extension ops (MUL..REMU).
//   Helpers : classify an op as divide-family, remainder or signed divide.
//   The FSM state encoding lives in riscv_base_muldiv.
package riscv_base_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Divide family: DIV, DIVU, REM, REMU.
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic md_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  // Signed divide ops (DIV, REM) have funct3[0] clear.
  function automatic logic md_is_signed_div(input logic [2:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/riscv_base_div_iter.sv
// riscv_base_div_iter
//   One restoring-division step, purely combinational.
//   The dividend is shifted out of the top of quo_i into the partial
//   remainder while quotient bits are shifted in at the bottom.
// Ports
//   rem_i     [XLEN:0]   partial remainder
//   quo_i     [XLEN-1:0] remaining dividend bits / quotient accumulated so far
//   divisor_i [XLEN-1:0] divisor magnitude
//   rem_o     [XLEN:0]   next partial remainder
//   quo_o     [XLEN-1:0] next dividend/quotient register
module riscv_base_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] rem_shift;
  logic [XLEN+1:0] diff;
  logic            borrow;

  always_comb begin
    // One extra bit above the remainder so the trial subtraction's
    // sign (borrow) is always visible.
    rem_shift = {rem_i, quo_i[XLEN-1]};
    diff      = rem_shift - {2'b00, divisor_i};
    borrow    = diff[XLEN+1];
    rem_o     = borrow ? rem_shift[XLEN:0] : diff[XLEN:0];
    quo_o     = {quo_i[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/riscv_base_muldiv.sv
// riscv_base_muldiv
//   Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
//   Multiply completes one cycle after accept; divide/remainder run an
//   iterative restoring divider (one quotient bit per cycle) followed by a
//   sign-fix cycle. Divide-by-zero and signed overflow are resolved at
//   accept time and go straight to DONE.
// Ports
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   flush_i     abort any op, return to IDLE (highest priority)
//   valid_i     request valid          ready_o  unit can accept (IDLE, not in reset)
//   op_i [2:0]  funct3 (md_op_e)       a_i/b_i  rs1/rs2 operands
//   valid_o     result valid (DONE)    ready_i  consumer takes result
//   res_o       result, stable while valid_o
//   dbg_state_o current FSM state
// Handshake: a request is accepted on a rising edge where valid_i && ready_o
//   && !flush_i; operands are captured then and later input changes are
//   ignored. A result is consumed on an edge where valid_o && ready_i.
module riscv_base_muldiv
  import riscv_base_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] res_o,
  output logic [2:0]      dbg_state_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [XLEN:0]   iter_rem;
  logic [XLEN-1:0] iter_quo;

  riscv_base_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (iter_rem),
    .quo_o     (iter_quo)
  );

  // Multiply datapath. Sign/zero-extending to 2*XLEN before the multiply
  // gives the same 2*XLEN product bits as an (XLEN+1)-bit signed multiply.
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_wide, b_wide, prod;

  always_comb begin
    a_sx   = (op_q != MD_MULHU) && a_q[XLEN-1];
    b_sx   = ((op_q == MD_MUL) || (op_q == MD_MULH)) && b_q[XLEN-1];
    a_wide = {{XLEN{a_sx}}, a_q};
    b_wide = {{XLEN{b_sx}}, b_q};
    prod   = a_wide * b_wide;
  end

  // Divide operand preparation and sign fix-up.
  logic            in_sdiv;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    in_sdiv = md_is_signed_div(op_i);
    a_mag   = (in_sdiv && a_i[XLEN-1]) ? -a_i : a_i;
    b_mag   = (in_sdiv && b_i[XLEN-1]) ? -b_i : b_i;
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          op_d = op_i;
          a_d  = a_i;
          b_d  = b_i;
          if (!md_is_div(op_i)) begin
            state_d = ST_MUL;
          end else if (b_i == '0) begin
            res_d   = md_is_rem(op_i) ? a_i : '1;
            state_d = ST_DONE;
          end else if (in_sdiv && (a_i == MIN_VAL) && (b_i == '1)) begin
            res_d   = md_is_rem(op_i) ? '0 : MIN_VAL;
            state_d = ST_DONE;
          end else begin
            quo_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = in_sdiv && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_rem_d = in_sdiv && a_i[XLEN-1];
            state_d   = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        res_d   = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d = ST_DONE;
      end
      ST_DIV: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d   = md_is_rem(op_q) ? rem_fix : quo_fix;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush wins over everything; the result register is only written
    // when DONE is actually entered, so it keeps its old value here.
    if (flush_i) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign ready_o     = (state_q == ST_IDLE) && !rst_i;
  assign valid_o     = (state_q == ST_DONE);
  assign res_o       = res_q;
  assign dbg_state_o = state_q;

endmodule
